// File: rtl/tone_sequencer.sv
// Melody sequencer: plays a 16-entry note table onto the one-hot tone select and the noise enable.
// Each entry has a 4-bit code and a 12-bit duration in ticks; a fixed silent gap follows every played entry.
module tone_sequencer #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [4:0]  len,
    input  logic        loop,
    input  logic        start,
    input  logic        stop,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cur_idx,
    output logic [9:0]  sel_nota,
    output logic        noise_en
);

    // state   | meaning
    // S_IDLE  | waiting for start, outputs silent
    // S_FETCH | one cycle: read mem[idx], skip zero-duration entries
    // S_PLAY  | drive the entry's tone/noise for duration ticks
    // S_GAP   | silent for GAP_TICKS ticks between entries
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int CW = (GW > 12) ? GW : 12;
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GAP_TC   = CW'(GAP_TICKS);

    logic [15:0] mem_q [16];

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [4:0]    len_q, len_d;
    logic [11:0]   dur_q, dur_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [9:0]    sel_q, sel_d;
    logic          noise_q, noise_d;

    logic [15:0]   fetch_word;
    logic [3:0]    fetch_code;
    logic [11:0]   fetch_dur;
    logic          tick_now;
    logic [CW-1:0] tick_inc;
    logic [4:0]    idx_inc;
    logic          last;
    logic          advance;

    // Table is deliberately not reset; writes are honoured in every state.
    always_ff @(posedge clk_clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_comb begin
        fetch_word = mem_q[idx_q];
        fetch_code = fetch_word[15:12];
        fetch_dur  = fetch_word[11:0];
        tick_now   = (presc_q == PRESC_TC);
        tick_inc   = tick_q + CW'(1);
        idx_inc    = {1'b0, idx_q} + 5'd1;
        last       = (idx_inc >= len_q);
        advance    = 1'b0;

        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        dur_d   = dur_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sel_d   = sel_q;
        noise_d = noise_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop && (len != 5'd0)) begin
                    len_d   = (len > 5'd16) ? 5'd16 : len;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                dur_d = fetch_dur;
                if (fetch_dur != 12'd0) begin
                    state_d = S_PLAY;
                    presc_d = '0;
                    tick_d  = '0;
                    sel_d   = (fetch_code <= 4'd9) ? (10'd1 << fetch_code) : 10'd0;
                    noise_d = (fetch_code == 4'd14);
                end else begin
                    advance = 1'b1;
                end
            end
            S_PLAY: begin
                if (tick_now) begin
                    presc_d = '0;
                    if (tick_inc == CW'(dur_q)) begin
                        if (GAP_TICKS != 0) begin
                            state_d = S_GAP;
                            tick_d  = '0;
                            sel_d   = 10'd0;
                            noise_d = 1'b0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        tick_d = tick_inc;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_GAP: begin
                if (tick_now) begin
                    presc_d = '0;
                    if (tick_inc == GAP_TC) advance = 1'b1;
                    else                    tick_d  = tick_inc;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        endcase

        if (advance) begin
            sel_d   = 10'd0;
            noise_d = 1'b0;
            if (!last) begin
                idx_d   = idx_inc[3:0];
                state_d = S_FETCH;
            end else if (loop) begin
                idx_d   = 4'd0;
                state_d = S_FETCH;
            end else begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end

        // Abort wins over everything, including a completion in the same cycle.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            sel_d   = 10'd0;
            noise_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            len_q   <= 5'd0;
            dur_q   <= 12'd0;
            presc_q <= '0;
            tick_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 10'd0;
            noise_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            noise_q <= noise_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_idx  = idx_q;
    assign sel_nota = sel_q;
    assign noise_en = noise_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=4, GAP_TICKS=1 (per-entry period (dur+1)*4+1).
module tb_tone_sequencer;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  len;
    logic        loop;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [3:0]  cur_idx;
    logic [9:0]  sel_nota;
    logic        noise_en;

    int checks = 0;
    int errors = 0;

    tone_sequencer #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .len(len),
        .loop(loop),
        .start(start),
        .stop(stop),
        .busy(busy),
        .done(done),
        .cur_idx(cur_idx),
        .sel_nota(sel_nota),
        .noise_en(noise_en)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
        len = 5'd0; loop = 1'b0; start = 1'b0; stop = 1'b0;

        #12;
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_idx",  0, 32'(cur_idx), 32'd0);
        chk("rst_sel",  0, 32'(sel_nota), 32'd0);
        chk("rst_noise", 0, 32'(noise_en), 32'd0);
        reset_reset_n = 1'b1;
        tick();
        tick();

        // Two tones; entry 1 rewritten while entry 0 plays, and a stray start while busy.
        wr(4'd0, 16'h0002);
        wr(4'd1, 16'h5001);
        len = 5'd2;
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            chk("a_sel", c, 32'(sel_nota),
                (c >= 2 && c <= 9) ? 32'h001 : (c >= 15 && c <= 18) ? 32'h200 : 32'h0);
            chk("a_noise", c, 32'(noise_en), 32'd0);
            chk("a_busy", c, 32'(busy), (c <= 22) ? 32'd1 : 32'd0);
            chk("a_done", c, 32'(done), (c == 23) ? 32'd1 : 32'd0);
            chk("a_idx", c, 32'(cur_idx), (c >= 14) ? 32'd1 : 32'd0);
            if (c == 4) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h9001;
            end
            if (c == 5) start = 1'b1;
            tick();
            wr_en = 1'b0;
            start = 1'b0;
        end

        // Noise burst then a rest entry.
        wr(4'd0, 16'hE003);
        wr(4'd1, 16'hF003);
        len = 5'd2;
        pulse_start();
        for (int c = 1; c <= 36; c++) begin
            chk("b_sel", c, 32'(sel_nota), 32'h0);
            chk("b_noise", c, 32'(noise_en), (c >= 2 && c <= 13) ? 32'd1 : 32'd0);
            chk("b_busy", c, 32'(busy), (c <= 34) ? 32'd1 : 32'd0);
            chk("b_done", c, 32'(done), (c == 35) ? 32'd1 : 32'd0);
            tick();
        end

        // Zero-duration middle entry costs a single fetch cycle.
        wr(4'd0, 16'h1001);
        wr(4'd1, 16'h0000);
        wr(4'd2, 16'h2001);
        len = 5'd3;
        pulse_start();
        for (int c = 1; c <= 21; c++) begin
            chk("c_sel", c, 32'(sel_nota),
                (c >= 2 && c <= 5) ? 32'h002 : (c >= 12 && c <= 15) ? 32'h004 : 32'h0);
            chk("c_busy", c, 32'(busy), (c <= 19) ? 32'd1 : 32'd0);
            chk("c_done", c, 32'(done), (c == 20) ? 32'd1 : 32'd0);
            chk("c_idx", c, 32'(cur_idx), (c <= 9) ? 32'd0 : (c == 10) ? 32'd1 : 32'd2);
            tick();
        end

        // Looping single entry, then abort mid-play.
        wr(4'd0, 16'h3001);
        len = 5'd1;
        loop = 1'b1;
        pulse_start();
        for (int c = 1; c <= 22; c++) begin
            chk("d_sel", c, 32'(sel_nota), (c >= 2 && ((c - 2) % 9) < 4) ? 32'h008 : 32'h0);
            chk("d_busy", c, 32'(busy), 32'd1);
            chk("d_done", c, 32'(done), 32'd0);
            if (c < 22) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop = 1'b0;
        for (int c = 23; c <= 26; c++) begin
            chk("d_stop_sel", c, 32'(sel_nota), 32'h0);
            chk("d_stop_busy", c, 32'(busy), 32'd0);
            chk("d_stop_done", c, 32'(done), 32'd0);
            tick();
        end

        // len=0 start, and start+stop together in idle, are both ignored.
        len = 5'd0;
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            chk("e_len0_busy", c, 32'(busy), 32'd0);
            chk("e_len0_done", c, 32'(done), 32'd0);
            tick();
        end
        len = 5'd1;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("e_ss_busy", c, 32'(busy), 32'd0);
            chk("e_ss_sel", c, 32'(sel_nota), 32'h0);
            tick();
        end

        // Asynchronous reset while entry 1 plays, then restart from entry 0.
        wr(4'd0, 16'h6001);
        wr(4'd1, 16'h7005);
        len = 5'd2;
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            if (c == 5) chk("f_sel0", c, 32'(sel_nota), 32'h040);
            tick();
        end
        chk("f_sel1", 13, 32'(sel_nota), 32'h080);
        chk("f_idx1", 13, 32'(cur_idx), 32'd1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk("f_rst_sel", 13, 32'(sel_nota), 32'h0);
        chk("f_rst_noise", 13, 32'(noise_en), 32'd0);
        chk("f_rst_busy", 13, 32'(busy), 32'd0);
        chk("f_rst_done", 13, 32'(done), 32'd0);
        chk("f_rst_idx", 13, 32'(cur_idx), 32'd0);
        #2;
        reset_reset_n = 1'b1;
        tick();
        pulse_start();
        chk("f_re_busy", 1, 32'(busy), 32'd1);
        chk("f_re_idx", 1, 32'(cur_idx), 32'd0);
        tick();
        chk("f_re_sel", 2, 32'(sel_nota), 32'h040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
